// File: rtl/pb_pkg.sv
// Shared definitions for the bouncing-pushbutton emulator: FSM encodings and
// the Galois LFSR polynomial / safe seed.
package pb_pkg;

  typedef logic [1:0] pb_state_t;

  localparam pb_state_t ST_IDLE   = 2'd0;
  localparam pb_state_t ST_BOUNCE = 2'd1;
  localparam pb_state_t ST_SETTLE = 2'd2;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used to randomise the bounce gaps. A zero seed is
// replaced by the default seed so the register can never lock up at zero.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);
  import pb_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      value <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/pb_bounce_gen.sv
// Bouncing-pushbutton emulator: on request, toggles pb_out 2*NUM_BOUNCES+1
// times with random gaps, then holds the final level before signalling done.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for a request; req_ready high
//   ST_BOUNCE | toggling pb_out, one toggle each time the gap expires
//   ST_SETTLE | pb_out stable at the final level for SETTLE_CYCLES
module pb_bounce_gen #(
  parameter int   NUM_BOUNCES   = 6,
  parameter int   GAP_W         = 8,
  parameter int   SETTLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_level,
  output logic        req_ready,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        pb_out,
  output logic        busy,
  output logic        done
);
  import pb_pkg::*;

  localparam int TOGGLES = 2 * NUM_BOUNCES + 1;
  localparam int CNT_W   = $clog2(TOGGLES + 1);
  localparam int SET_W   = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_TGL = CNT_W'(TOGGLES - 1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [GAP_W:0]   GAP_ONE  = (GAP_W + 1)'(1);

  pb_state_t         state;
  logic [GAP_W:0]    gap;
  logic [CNT_W-1:0]  tgl_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [15:0]       lfsr_val;
  logic [GAP_W:0]    gap_draw;
  logic              lfsr_unused;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seed_load),
    .seed    (seed),
    .advance (1'b1),
    .value   (lfsr_val)
  );

  // Gap range is 1..2^GAP_W, hence the extra bit.
  assign gap_draw    = {1'b0, lfsr_val[GAP_W-1:0]} + GAP_ONE;
  assign lfsr_unused = ^lfsr_val;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_BOUNCE) || (state == ST_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pb_out     <= RESET_LEVEL;
      done       <= 1'b0;
      gap        <= '0;
      tgl_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_level == pb_out) begin
              state      <= ST_SETTLE;
              settle_cnt <= SET_INIT;
            end else begin
              state   <= ST_BOUNCE;
              tgl_cnt <= '0;
              gap     <= gap_draw;
            end
          end
        end
        ST_BOUNCE: begin
          if (gap == GAP_ONE) begin
            pb_out  <= ~pb_out;
            tgl_cnt <= tgl_cnt + 1'b1;
            gap     <= gap_draw;
            // Odd toggle count from the opposite level lands on req_level.
            if (tgl_cnt == LAST_TGL) begin
              state      <= ST_SETTLE;
              settle_cnt <= SET_INIT;
            end
          end else begin
            gap <= gap - GAP_ONE;
          end
        end
        ST_SETTLE: begin
          // A zero-length settle still costs one cycle before done.
          if (settle_cnt <= SET_ONE) begin
            state      <= ST_IDLE;
            done       <= 1'b1;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt - SET_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
